// File: rtl/top_servo.sv
// rtl/top_servo.sv - servo PWM generator with proportional position correction and latched overcurrent trip
// Width is recomputed only at the frame wrap, so mid-frame input changes never disturb the running pulse.
module top_servo #(
  parameter int PWM_PERIOD = 2000000,
  parameter int MIN_PULSE  = 100000,
  parameter int STEP       = 556,
  parameter int KP_SHIFT   = 1,
  parameter int I_LIMIT    = 1500,
  parameter int OC_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  grades,
  input  logic [11:0] measure_current,
  input  logic [7:0]  measure_grades,
  output logic        pwm_out
);

  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int OW = $clog2(OC_CYCLES + 1);
  localparam logic [CW-1:0] LAST      = CW'(PWM_PERIOD - 1);
  localparam logic [31:0]   MIN_W     = 32'(MIN_PULSE);
  localparam logic [31:0]   STEP_W    = 32'(STEP);
  localparam logic [11:0]   ILIM      = 12'(I_LIMIT);
  localparam logic [OW-1:0] OC_MAX    = OW'(OC_CYCLES);
  localparam logic [7:0]    MAX_DEG   = 8'd180;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_width;
  logic [OW-1:0] r_oc;
  logic          r_fault;
  logic          r_pwm;

  logic [7:0]        w_cmd;
  logic [7:0]        w_meas;
  logic signed [8:0] w_err;
  logic signed [9:0] w_err_x;
  logic signed [9:0] w_corr_raw;
  logic [7:0]        w_corr;
  logic [31:0]       w_new_width;
  logic [31:0]       w_width_eff;
  logic              w_frame_start;
  logic              w_over;
  logic [OW-1:0]     w_oc_next;
  logic              w_fault_next;

  always_comb begin
    w_cmd      = (grades > MAX_DEG) ? MAX_DEG : grades;
    w_meas     = (measure_grades > MAX_DEG) ? MAX_DEG : measure_grades;
    w_err      = $signed({1'b0, w_cmd}) - $signed({1'b0, w_meas});
    w_err_x    = {w_err[8], w_err};
    w_corr_raw = $signed({2'b00, w_cmd}) + (w_err_x >>> KP_SHIFT);
    if (w_corr_raw < 0)
      w_corr = 8'd0;
    else if (w_corr_raw > $signed({2'b00, MAX_DEG}))
      w_corr = MAX_DEG;
    else
      w_corr = w_corr_raw[7:0];
    w_new_width   = MIN_W + ({24'd0, w_corr} * STEP_W);
    w_frame_start = (r_cnt == '0);
    w_width_eff   = w_frame_start ? w_new_width : r_width;
  end

  // Consecutive over-limit counter saturates at the trip level; the trip also blanks pwm on the same edge.
  always_comb begin
    w_over = (measure_current > ILIM);
    if (!w_over)
      w_oc_next = '0;
    else if (r_oc == OC_MAX)
      w_oc_next = r_oc;
    else
      w_oc_next = r_oc + OW'(1);
    w_fault_next = r_fault | (w_oc_next == OC_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cnt   <= '0;
      r_width <= MIN_W;
      r_oc    <= '0;
      r_fault <= 1'b0;
      r_pwm   <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      if (w_frame_start)
        r_width <= w_new_width;
      r_oc    <= w_oc_next;
      r_fault <= w_fault_next;
      r_pwm   <= !w_fault_next && ({{(32-CW){1'b0}}, r_cnt} < w_width_eff);
    end
  end

  assign pwm_out = r_pwm;

endmodule

// File: tb/tb_top_servo.sv
// tb/tb_top_servo.sv - self-checking bench for top_servo against a frame-level pulse-width model
module tb_top_servo;

  localparam int PERIOD = 1000;
  localparam int MINP   = 50;
  localparam int STP    = 1;
  localparam int KP     = 1;
  localparam int ILIM   = 1500;
  localparam int OCN    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  grades = 8'd0;
  logic [11:0] measure_current = 12'd0;
  logic [7:0]  measure_grades = 8'd0;
  logic        pwm_out;

  int total = 0;
  int bad   = 0;

  top_servo #(
    .PWM_PERIOD(PERIOD), .MIN_PULSE(MINP), .STEP(STP),
    .KP_SHIFT(KP), .I_LIMIT(ILIM), .OC_CYCLES(OCN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .grades(grades),
    .measure_current(measure_current), .measure_grades(measure_grades),
    .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected high time of a frame, from the angle rules with floor division standing in for the shift.
  function automatic int exp_width(input int g, input int m);
    int c, ms, e, d, sh, corr;
    c  = (g > 180) ? 180 : g;
    ms = (m > 180) ? 180 : m;
    e  = c - ms;
    d  = 1 << KP;
    sh = (e >= 0) ? (e / d) : -((-e + d - 1) / d);
    corr = c + sh;
    if (corr < 0) corr = 0;
    if (corr > 180) corr = 180;
    return MINP + corr * STP;
  endfunction

  // One full frame: count high samples and find the first low one; optionally queue next-frame inputs
  // and an over-limit current burst (oc_len cycles of ILIM+1 followed by exactly ILIM).
  task automatic run_frame(input int exp_w, input string tag, input int chg_at,
                           input int g, input int m, input int oc_at, input int oc_len);
    int hi = 0;
    int first_low = -1;
    for (int j = 0; j < PERIOD; j++) begin
      @(posedge clk); #1;
      if (pwm_out === 1'b1) hi++;
      else if (first_low < 0) first_low = j;
      if (j == chg_at) begin
        grades = 8'(g);
        measure_grades = 8'(m);
      end
      if (j >= oc_at && j < oc_at + oc_len) measure_current = 12'(ILIM + 1);
      else if (j == oc_at + oc_len) measure_current = 12'(ILIM);
      else measure_current = 12'($urandom_range(0, ILIM));
    end
    chk({tag, "_high"}, hi, exp_w);
    chk({tag, "_edge"}, first_low, (exp_w < PERIOD) ? exp_w : -1);
  endtask

  initial begin
    int w_next, g, m, at;

    rst_n = 1'b1;
    grades = 8'($urandom);
    measure_grades = 8'($urandom);
    measure_current = 12'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("reset_pwm", int'(pwm_out), 0);
    end
    measure_current = 12'd0;
    grades = 8'd90;
    measure_grades = 8'd90;
    rst_n = 1'b0;

    run_frame(140, "hold90a", 500, 90, 90, -10, 0);
    run_frame(140, "hold90b", 500, 90, 70, -10, 0);
    run_frame(150, "meas70", 500, 90, 110, -10, 0);
    run_frame(130, "meas110", 200, 200, 180, -10, 0);
    run_frame(230, "cmd_clamp", 10, 0, 180, -10, 0);
    run_frame(50, "corr_clamp", 500, 90, 90, -10, 0);
    run_frame(140, "midframe_chg", 500, 0, 90, -10, 0);
    run_frame(50, "after_chg", 100, 90, 90, 100, 15);
    run_frame(140, "oc15_nofault", 300, 90, 90, 20, 0);

    w_next = 140;
    for (int k = 0; k < 6; k++) begin
      g  = $urandom_range(0, 255);
      m  = $urandom_range(0, 255);
      at = $urandom_range(0, PERIOD - 1);
      run_frame(w_next, $sformatf("rand%0d", k), at, g, m, -10, 0);
      w_next = exp_width(g, m);
    end
    run_frame(w_next, "rand_last", 0, 90, 90, -10, 0);

    // Trip in the middle of the 140-cycle pulse: 16 over-limit cycles starting at sample 20.
    run_frame(36, "oc_trip", PERIOD, 0, 0, 20, 16);
    run_frame(0, "faulted_a", PERIOD, 0, 0, -10, 0);
    for (int j = 0; j < PERIOD; j++) begin
      measure_current = 12'd0;
      @(posedge clk); #1;
      if (pwm_out !== 1'b0) begin
        chk("faulted_zero_current", int'(pwm_out), 0);
        break;
      end
    end
    chk("faulted_latched", int'(pwm_out), 0);

    rst_n = 1'b1;
    grades = 8'd90;
    measure_grades = 8'd90;
    @(posedge clk); #1;
    chk("fault_reset_pwm", int'(pwm_out), 0);
    rst_n = 1'b0;
    run_frame(140, "post_reset", PERIOD, 0, 0, -10, 0);

    for (int j = 0; j < 50; j++) begin
      @(posedge clk); #1;
    end
    chk("pre_midreset_high", int'(pwm_out), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset_pwm", int'(pwm_out), 0);
    grades = 8'd90;
    measure_grades = 8'd70;
    rst_n = 1'b0;
    run_frame(150, "restart_frame", PERIOD, 0, 0, -10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
